// File: rtl/dft_stream_framer.sv
// Frames a raw complex sample stream into sop/eop-delimited Avalon-ST frames for the mixed-radix DFT core.
// Optional frame/error statistics outputs are enabled by defining DFT_FRAMER_STATS_EN.
module dft_stream_framer #(
  parameter int DW    = 18,
  parameter int PTS_W = 12,
  parameter int GAP_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PTS_W-1:0] cfg_dftpts,
  input  logic             cfg_inverse,
  input  logic [GAP_W-1:0] cfg_gap,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_real,
  input  logic [DW-1:0]    in_imag,
  output logic             sink_valid,
  input  logic             sink_ready,
  output logic             sink_sop,
  output logic             sink_eop,
  output logic [DW-1:0]    sink_real,
  output logic [DW-1:0]    sink_imag,
  output logic [5:0]       size,
  output logic             inverse,
  output logic             busy
`ifdef DFT_FRAMER_STATS_EN
  ,
  output logic [15:0]      stat_frames,
  output logic [7:0]       stat_errs
`endif
);

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t           state, next_state;
  logic             armed;
  logic [PTS_W-1:0] pts_q;
  logic [PTS_W-1:0] rem;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [6:0]       size_hit;
  logic             cfg_fire;
  logic             cfg_ok;
  logic             in_fire;
  logic             eop_fire;

  // Bit 6 flags a supported point count, bits 5:0 carry the core's size code.
  function automatic logic [6:0] lookup_size(input logic [PTS_W-1:0] pts);
    case (pts)
      PTS_W'(12):   return {1'b1, 6'd0};
      PTS_W'(24):   return {1'b1, 6'd1};
      PTS_W'(36):   return {1'b1, 6'd2};
      PTS_W'(48):   return {1'b1, 6'd3};
      PTS_W'(60):   return {1'b1, 6'd4};
      PTS_W'(72):   return {1'b1, 6'd5};
      PTS_W'(96):   return {1'b1, 6'd6};
      PTS_W'(108):  return {1'b1, 6'd7};
      PTS_W'(120):  return {1'b1, 6'd8};
      PTS_W'(144):  return {1'b1, 6'd9};
      PTS_W'(180):  return {1'b1, 6'd10};
      PTS_W'(192):  return {1'b1, 6'd11};
      PTS_W'(216):  return {1'b1, 6'd12};
      PTS_W'(240):  return {1'b1, 6'd13};
      PTS_W'(288):  return {1'b1, 6'd14};
      PTS_W'(300):  return {1'b1, 6'd15};
      PTS_W'(324):  return {1'b1, 6'd16};
      PTS_W'(360):  return {1'b1, 6'd17};
      PTS_W'(384):  return {1'b1, 6'd18};
      PTS_W'(432):  return {1'b1, 6'd19};
      PTS_W'(480):  return {1'b1, 6'd20};
      PTS_W'(540):  return {1'b1, 6'd21};
      PTS_W'(576):  return {1'b1, 6'd22};
      PTS_W'(600):  return {1'b1, 6'd23};
      PTS_W'(648):  return {1'b1, 6'd24};
      PTS_W'(720):  return {1'b1, 6'd25};
      PTS_W'(768):  return {1'b1, 6'd26};
      PTS_W'(864):  return {1'b1, 6'd27};
      PTS_W'(900):  return {1'b1, 6'd28};
      PTS_W'(960):  return {1'b1, 6'd29};
      PTS_W'(972):  return {1'b1, 6'd30};
      PTS_W'(1080): return {1'b1, 6'd31};
      PTS_W'(1152): return {1'b1, 6'd32};
      PTS_W'(1200): return {1'b1, 6'd33};
      default:      return 7'd0;
    endcase
  endfunction

  assign size_hit = lookup_size(cfg_dftpts);
  assign cfg_ok   = size_hit[6];
  assign cfg_fire = cfg_valid && cfg_ready;
  assign in_fire  = in_valid && in_ready;
  assign eop_fire = sink_valid && sink_ready && sink_eop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cfg_fire && cfg_ok) next_state = STREAM;
      STREAM:  if (eop_fire) next_state = (gap_q == '0) ? IDLE : GAP;
      GAP:     if (gap_cnt <= GAP_W'(1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // cfg_ready is held low until the first clock after reset release so every output reads 0 in reset.
  always_comb begin
    cfg_ready = (state == IDLE) && armed;
    in_ready  = (state == STREAM) && (!sink_valid || sink_ready) && (rem != '0);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      cfg_err <= 1'b0;
      pts_q   <= '0;
      gap_q   <= '0;
      size    <= '0;
      inverse <= 1'b0;
    end else begin
      armed   <= 1'b1;
      cfg_err <= cfg_fire && !cfg_ok;
      if (cfg_fire && cfg_ok) begin
        pts_q   <= cfg_dftpts;
        gap_q   <= cfg_gap;
        size    <= size_hit[5:0];
        inverse <= cfg_inverse;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      gap_cnt <= '0;
    end else begin
      if (cfg_fire && cfg_ok) rem <= cfg_dftpts;
      else if (in_fire)       rem <= rem - PTS_W'(1);
      if (state == STREAM && eop_fire) gap_cnt <= gap_q;
      else if (state == GAP)           gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  // rem still holds the full point count when the first beat is accepted, and 1 on the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sink_valid <= 1'b0;
      sink_sop   <= 1'b0;
      sink_eop   <= 1'b0;
      sink_real  <= '0;
      sink_imag  <= '0;
    end else if (in_fire) begin
      sink_valid <= 1'b1;
      sink_sop   <= (rem == pts_q);
      sink_eop   <= (rem == PTS_W'(1));
      sink_real  <= in_real;
      sink_imag  <= in_imag;
    end else if (sink_ready) begin
      sink_valid <= 1'b0;
      sink_sop   <= 1'b0;
      sink_eop   <= 1'b0;
    end
  end

`ifdef DFT_FRAMER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_errs   <= '0;
    end else begin
      if (eop_fire) stat_frames <= stat_frames + 16'd1;
      if (cfg_err && stat_errs != 8'hFF) stat_errs <= stat_errs + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dft_stream_framer.sv
// Scoreboard bench for dft_stream_framer: accepted samples are queued as expected beats, a monitor pops on each transfer.
// Statistics checks are compiled in when DFT_FRAMER_STATS_EN is defined.
module tb_dft_stream_framer;
  localparam int DW = 18, PTS_W = 12, GAP_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cfg_valid = 1'b0, cfg_ready, cfg_inverse = 1'b0, cfg_err;
  logic [PTS_W-1:0] cfg_dftpts = '0;
  logic [GAP_W-1:0] cfg_gap = '0;
  logic in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_real = '0, in_imag = '0;
  logic sink_valid, sink_ready = 1'b1, sink_sop, sink_eop, inverse, busy;
  logic [DW-1:0] sink_real, sink_imag;
  logic [5:0] size;
`ifdef DFT_FRAMER_STATS_EN
  logic [15:0] stat_frames;
  logic [7:0]  stat_errs;
`endif

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          sop;
    logic          eop;
    logic [5:0]    sz;
    logic          inv;
  } beat_t;

  beat_t expq[$];
  beat_t held;
  bit    hold_pending = 0;
  int    checks = 0, errors = 0;
  int    ready_mode = 0;
  logic [5:0] cur_size = '0;
  logic       cur_inv = 1'b0;
  int size_tab[34] = '{12, 24, 36, 48, 60, 72, 96, 108, 120, 144, 180, 192, 216, 240, 288, 300, 324,
                       360, 384, 432, 480, 540, 576, 600, 648, 720, 768, 864, 900, 960, 972, 1080, 1152, 1200};

  dft_stream_framer #(.DW(DW), .PTS_W(PTS_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_dftpts(cfg_dftpts),
    .cfg_inverse(cfg_inverse), .cfg_gap(cfg_gap), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag), .size(size), .inverse(inverse), .busy(busy)
`ifdef DFT_FRAMER_STATS_EN
    , .stat_frames(stat_frames), .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  function automatic int size_code(input int pts);
    foreach (size_tab[i]) if (size_tab[i] == pts) return i;
    return -1;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready pattern: always ready, alternating, or random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       sink_ready = 1'b1;
      1:       sink_ready = ~sink_ready;
      default: sink_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    beat_t cur;
    if (!rst_n) begin
      hold_pending = 0;
    end else begin
      cur = '{re: sink_real, im: sink_imag, sop: sink_sop, eop: sink_eop, sz: size, inv: inverse};
      if (hold_pending) check_output("hold_stable", {sink_valid, cur}, {1'b1, held});
      hold_pending = 0;
      if (sink_valid) begin
        if (sink_ready) begin
          if (expq.size() == 0) check_output("unexpected_beat", 64'(cur), 64'hDEAD);
          else check_output("beat", 64'(cur), 64'(expq.pop_front()));
        end else begin
          held = cur;
          hold_pending = 1;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    in_valid = 1'b0;
    expq.delete();
    cur_size = '0;
    cur_inv = 1'b0;
    #1;
    check_output("reset_outputs",
                 64'({sink_valid, sink_sop, sink_eop, sink_real, sink_imag, size, inverse, busy, cfg_ready, cfg_err, in_ready}),
                 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_config(input int pts, input bit inv, input int gap);
    int code, n;
    cfg_dftpts = PTS_W'(pts);
    cfg_inverse = inv;
    cfg_gap = GAP_W'(gap);
    cfg_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (cfg_ready) break;
      if (++n > 5000) begin
        check_output("cfg_ready_timeout", 64'd0, 64'd1);
        cfg_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    code = size_code(pts);
    if (code >= 0) begin
      cur_size = 6'(code);
      cur_inv = inv;
      check_output("cfg_size_inv", 64'({size, inverse, cfg_err}), 64'({cur_size, cur_inv, 1'b0}));
    end else begin
      check_output("cfg_err_pulse", 64'({cfg_err, size, inverse, sink_valid}), 64'({1'b1, cur_size, cur_inv, 1'b0}));
      @(posedge clk);
      #1;
      check_output("cfg_err_single", 64'({cfg_err, busy}), 64'd0);
    end
  endtask

  task automatic apply_stimulus(input int pts, input bit rand_valid, input int stop_at);
    int k = 0, n = 0;
    bit acc;
    beat_t b;
    while (k < stop_at) begin
      in_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_real = DW'($urandom);
      in_imag = DW'($urandom);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) begin
        b = '{re: in_real, im: in_imag, sop: (k == 0), eop: (k == pts - 1), sz: cur_size, inv: cur_inv};
        expq.push_back(b);
      end
      @(posedge clk);
      #1;
      if (acc) k++;
      if (++n > 20000) begin
        check_output("input_timeout", 64'(k), 64'(stop_at));
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic measure_gap(input int gap);
    int n = 0;
    forever begin
      @(negedge clk);
      if (sink_valid && sink_ready && sink_eop) break;
      if (++n > 20000) begin
        check_output("eop_timeout", 64'd0, 64'd1);
        return;
      end
    end
    n = 0;
    forever begin
      @(negedge clk);
      if (cfg_ready) break;
      if (++n > 20000) break;
    end
    check_output("gap_len", 64'(n), 64'(gap));
    check_output("queue_drained", 64'(expq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    do_reset();

    ready_mode = 0;
    apply_config(1200, 0, 0);
    apply_stimulus(1200, 0, 1200);
    measure_gap(0);

    apply_config(100, 1, 3);
    apply_config(12, 0, 0);
    apply_stimulus(12, 0, 12);
    measure_gap(0);

    ready_mode = 1;
    apply_config(48, 1, 2);
    apply_stimulus(48, 0, 48);
    measure_gap(2);

    ready_mode = 0;
    apply_config(12, 0, 5);
    fork
      begin
        apply_stimulus(12, 0, 12);
        measure_gap(5);
      end
      apply_config(12, 1, 0);
    join
    apply_stimulus(12, 0, 12);
    measure_gap(0);

    ready_mode = 2;
    for (int f = 0; f < 5; f++) begin
      int pts, gap;
      bit inv;
      pts = size_tab[$urandom_range(0, 8)];
      gap = $urandom_range(0, 6);
      inv = 1'($urandom_range(0, 1));
      apply_config(pts, inv, gap);
      apply_stimulus(pts, 1, pts);
      measure_gap(gap);
    end

    ready_mode = 0;
    apply_config(1200, 1, 0);
    apply_stimulus(1200, 0, 300);
    do_reset();
    apply_config(24, 0, 1);
    apply_stimulus(24, 0, 24);
    measure_gap(1);
    apply_config(7, 1, 0);
    apply_config(12, 1, 0);
    apply_stimulus(12, 1, 12);
    measure_gap(0);
    apply_config(13, 0, 0);
    apply_config(36, 0, 2);
    apply_stimulus(36, 0, 36);
    measure_gap(2);
`ifdef DFT_FRAMER_STATS_EN
    check_output("stat_frames", 64'(stat_frames), 64'd3);
    check_output("stat_errs", 64'(stat_errs), 64'd2);
`endif

    repeat (4) @(posedge clk);
    check_output("final_queue_empty", 64'(expq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
